// File: rtl/ps2_host_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_host_tx_pkg
//  Brief    : Shared PS/2 definitions: host transmitter state encoding,
//             frame geometry, common command bytes and frame builder.
//  Revision : 1.0 - initial release
// ============================================================================
package ps2_host_tx_pkg;

    // Start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS = 11;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        RTS       = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5,
        ABORT     = 3'd6
    } ps2_tx_state_t;

    // Full frame indexed in transmit order: bit 0 = start (0), bits 1..8 =
    // data LSB first, bit 9 = odd parity, bit 10 = stop (1).
    function automatic logic [PS2_FRAME_BITS-1:0] ps2_build_frame(input logic [7:0] data);
        return {1'b1, ~^data, data, 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_line_filter
//  Brief    : Synchronizes an asynchronous PS/2 line, debounces it so the
//             filtered level only follows after FILTER_LEN identical samples,
//             and emits a one-cycle pulse on each filtered 1->0 transition.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic level,
    output logic fall
);

    localparam int                c_cnt_w    = $clog2(FILTER_LEN) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FILTER_LEN - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_level;
    logic               r_fall;

    // Two-flop synchronizer, disagreement counter and filtered level/fall.
    // The counter restarts whenever the sample agrees with the filtered
    // level, so short glitches never accumulate toward a change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
        end else begin
            r_sync1 <= line_in;
            r_sync2 <= r_sync1;
            r_fall  <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt >= c_cnt_last) begin
                r_level <= r_sync2;
                r_fall  <= r_level & ~r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_host_tx
//  Brief    : PS/2 host-to-device transmitter. Inhibits the clock, issues a
//             request-to-send, shifts out one byte on device-generated clock
//             falls, samples the device ack and reports done/error. Drives
//             only active-low output enables; tristating happens above.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       CPU_RESETN,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int                  c_inhib_w    = $clog2(INHIBIT_CYCLES) + 1;
    localparam int                  c_tout_w     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [c_inhib_w-1:0] c_inhib_last = c_inhib_w'(INHIBIT_CYCLES - 1);
    localparam logic [c_tout_w-1:0]  c_tout_last  = c_tout_w'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]           c_stop_idx   = 4'(PS2_FRAME_BITS - 1);

    ps2_tx_state_t               r_state;
    ps2_tx_state_t               w_next_state;
    logic [PS2_FRAME_BITS-1:0]   r_frame;
    logic [3:0]                  r_bit_idx;
    logic                        r_data_low;
    logic                        r_nack;
    logic [c_inhib_w-1:0]        r_inhib_cnt;
    logic [c_tout_w-1:0]         r_tout_cnt;

    logic w_clk_level;
    logic w_clk_fall;
    logic w_data_level;
    logic w_data_fall_unused;
    logic w_timeout;
    logic w_accept;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk     (clk),
        .rst_n   (CPU_RESETN),
        .line_in (ps2_clk_in),
        .level   (w_clk_level),
        .fall    (w_clk_fall)
    );

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_data_filter (
        .clk     (clk),
        .rst_n   (CPU_RESETN),
        .line_in (ps2_data_in),
        .level   (w_data_level),
        .fall    (w_data_fall_unused)
    );

    // Timeout only counts while the device owns the clock.
    assign w_timeout = (r_tout_cnt >= c_tout_last);
    assign w_accept  = (r_state == IDLE) && tx_valid;
    assign tx_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (!CPU_RESETN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and line/handshake outputs; timeout outranks any clock fall.
    always_comb begin
        w_next_state = r_state;
        ps2_clk_oe   = 1'b0;
        ps2_data_oe  = 1'b0;
        tx_done      = 1'b0;
        tx_err       = 1'b0;
        case (r_state)
            IDLE: begin
                if (tx_valid) begin
                    w_next_state = INHIBIT;
                end
            end
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (r_inhib_cnt >= c_inhib_last) begin
                    w_next_state = RTS;
                end
            end
            RTS: begin
                ps2_clk_oe   = 1'b1;
                ps2_data_oe  = 1'b1;
                w_next_state = SEND;
            end
            SEND: begin
                ps2_data_oe = r_data_low;
                if (w_timeout) begin
                    w_next_state = ABORT;
                end else if (w_clk_fall && (r_bit_idx == c_stop_idx)) begin
                    w_next_state = ACK;
                end
            end
            ACK: begin
                if (w_timeout) begin
                    w_next_state = ABORT;
                end else if (w_clk_fall) begin
                    w_next_state = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (w_timeout) begin
                    w_next_state = ABORT;
                end else if (w_clk_level && w_data_level) begin
                    tx_done      = 1'b1;
                    tx_err       = r_nack;
                    w_next_state = IDLE;
                end
            end
            ABORT: begin
                tx_done      = 1'b1;
                tx_err       = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Datapath: frame latch, bit shifter, ack capture and saturating counters.
    always_ff @(posedge clk) begin
        if (!CPU_RESETN) begin
            r_frame     <= '0;
            r_bit_idx   <= '0;
            r_data_low  <= 1'b0;
            r_nack      <= 1'b0;
            r_inhib_cnt <= '0;
            r_tout_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_frame <= ps2_build_frame(tx_data);
            end

            if (r_state == INHIBIT) begin
                if (!(&r_inhib_cnt)) begin
                    r_inhib_cnt <= r_inhib_cnt + 1'b1;
                end
            end else begin
                r_inhib_cnt <= '0;
            end

            if ((r_state == SEND) || (r_state == ACK) || (r_state == WAIT_IDLE)) begin
                if (!(&r_tout_cnt)) begin
                    r_tout_cnt <= r_tout_cnt + 1'b1;
                end
            end else begin
                r_tout_cnt <= '0;
            end

            // The start bit is already on the line when SEND begins, so the
            // first clock fall presents frame bit 1 (data LSB).
            if (r_state == RTS) begin
                r_data_low <= 1'b1;
                r_bit_idx  <= 4'd1;
            end else if ((r_state == SEND) && w_clk_fall && !w_timeout) begin
                r_data_low <= ~r_frame[r_bit_idx];
                if (r_bit_idx < c_stop_idx) begin
                    r_bit_idx <= r_bit_idx + 1'b1;
                end
            end

            if ((r_state == ACK) && w_clk_fall && !w_timeout) begin
                r_nack <= w_data_level;
            end
        end
    end

endmodule
`default_nettype wire
